// File: rtl/danger_pkg.sv
// Shared types for the obstacle scheduler: type codes, game states,
// field widths, FSM states and the random-to-obstacle type map.
package danger_pkg;

    localparam int POS_W   = 10;
    localparam int TYPE_W  = 3;
    localparam int SPEED_W = 4;
    localparam int DIST_W  = 11;

    typedef enum logic [TYPE_W-1:0] {
        T_LOW_BIRD     = 3'd0,
        T_HIGH_BIRD    = 3'd1,
        T_SMALL_CACTUS = 3'd2,
        T_MANY_CACTUS  = 3'd3,
        T_BIG_CACTUS   = 3'd4,
        T_NOTHING      = 3'd5
    } danger_type_e;

    typedef enum logic [1:0] {
        GS_INIT  = 2'd0,
        GS_START = 2'd1,
        GS_END   = 2'd2,
        GS_RESET = 2'd3
    } game_state_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_FREEZE,
        ST_CLEAR
    } sched_state_e;

    // 3 random bits -> obstacle type; birds only when allowed,
    // otherwise the bird codes fold onto cactus types.
    function automatic logic [TYPE_W-1:0] map_type(
        input logic [2:0] r,
        input logic       birds_ok
    );
        logic [TYPE_W-1:0] t;
        unique case (r)
            3'd0:    t = birds_ok ? T_LOW_BIRD : T_SMALL_CACTUS;
            3'd1:    t = birds_ok ? T_HIGH_BIRD : T_BIG_CACTUS;
            3'd5:    t = T_SMALL_CACTUS;
            3'd6:    t = T_MANY_CACTUS;
            3'd7:    t = T_BIG_CACTUS;
            default: t = r;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/danger_scheduler_if.sv
// Bus between game FSM / scheduler / renderer.
// master = scheduler (reads game_state, frame_tick; drives slots).
interface danger_scheduler_if;
    import danger_pkg::*;

    logic [1:0]        game_state;
    logic              frame_tick;
    logic [POS_W-1:0]  new_danger_pos1;
    logic [POS_W-1:0]  new_danger_pos2;
    logic [POS_W-1:0]  new_danger_pos3;
    logic [TYPE_W-1:0] danger_type1;
    logic [TYPE_W-1:0] danger_type2;
    logic [TYPE_W-1:0] danger_type3;
    logic              danger_en1;
    logic              danger_en2;
    logic              danger_en3;
    logic [SPEED_W-1:0] cur_speed;

    modport master (
        input  game_state, frame_tick,
        output new_danger_pos1, new_danger_pos2, new_danger_pos3,
        output danger_type1, danger_type2, danger_type3,
        output danger_en1, danger_en2, danger_en3, cur_speed
    );

    modport slave (
        output game_state, frame_tick,
        input  new_danger_pos1, new_danger_pos2, new_danger_pos3,
        input  danger_type1, danger_type2, danger_type3,
        input  danger_en1, danger_en2, danger_en3, cur_speed
    );

endinterface

// File: rtl/danger_lfsr16.sv
// 16-bit Galois LFSR (taps 16'hB400). Ports: clk, rst, step, load,
// type_bits = state[2:0], gap_bits = state[13:8].
module danger_lfsr16 #(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       step,
    input  logic       load,
    output logic [2:0] type_bits,
    output logic [5:0] gap_bits
);

    logic [15:0] lfsr_q, lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q;
        if (load) begin
            lfsr_d = SEED;
        end else if (step) begin
            lfsr_d = {1'b0, lfsr_q[15:1]}
                   ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) lfsr_q <= SEED;
        else     lfsr_q <= lfsr_d;
    end

    assign type_bits = lfsr_q[2:0];
    assign gap_bits  = lfsr_q[13:8];

endmodule

// File: rtl/danger_scheduler.sv
// Obstacle scheduler: spawns, scrolls and retires three slots, ramps speed.
// Ports: clk, rst (async high), bus (master: game_state/frame_tick in,
// slot pos/type/en and cur_speed out). Optional macro DANGER_BIRD_EN.
module danger_scheduler
    import danger_pkg::*;
#(
    parameter int          SPAWN_X           = 700,
    parameter int          MIN_GAP           = 200,
    parameter int          SPEED_INIT        = 4,
    parameter int          SPEED_MAX         = 12,
    parameter int          SPEED_STEP_FRAMES = 512,
    parameter logic [15:0] LFSR_SEED         = 16'hACE1
) (
    input  logic               clk,
    input  logic               rst,
    danger_scheduler_if.master bus
);

    localparam int CNT_W = $clog2(SPEED_STEP_FRAMES + 1);
    localparam logic [2:0][TYPE_W-1:0] TYPE_RST =
        {3{TYPE_W'(T_NOTHING)}};

    sched_state_e            state_q, state_d;
    logic [2:0][POS_W-1:0]   pos_q, pos_d;
    logic [2:0][TYPE_W-1:0]  type_q, type_d;
    logic [2:0]              en_q, en_d;
    logic [SPEED_W-1:0]      speed_q, speed_d;
    logic [DIST_W-1:0]       dist_q, dist_d;
    logic [DIST_W-1:0]       gap_q, gap_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [DIST_W:0]         dist_sum;
    logic                    tick_upd, clear, spawned, birds_ok;
    logic [2:0]              rnd_type;
    logic [5:0]              rnd_gap;

`ifdef DANGER_BIRD_EN
    assign birds_ok = speed_q >= SPEED_W'(SPEED_INIT + 2);
`else
    assign birds_ok = 1'b0;
`endif

    danger_lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
        .clk       (clk),
        .rst       (rst),
        .step      (tick_upd),
        .load      (clear),
        .type_bits (rnd_type),
        .gap_bits  (rnd_gap)
    );

    always_comb begin
        state_d  = state_q;
        pos_d    = pos_q;
        type_d   = type_q;
        en_d     = en_q;
        speed_d  = speed_q;
        dist_d   = dist_q;
        gap_d    = gap_q;
        cnt_d    = cnt_q;
        dist_sum = '0;
        spawned  = 1'b0;

        unique case (state_q)
            ST_IDLE:   if (bus.game_state == GS_START) state_d = ST_RUN;
            ST_RUN: begin
                if (bus.game_state == GS_END)       state_d = ST_FREEZE;
                else if (bus.game_state == GS_INIT) state_d = ST_IDLE;
            end
            ST_FREEZE: state_d = ST_FREEZE;
            ST_CLEAR:  state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
        if (bus.game_state == GS_RESET) state_d = ST_CLEAR;

        // A transition in the tick cycle takes priority over motion.
        tick_upd = bus.frame_tick && state_q == ST_RUN
                && state_d == ST_RUN;
        clear    = state_d == ST_CLEAR;

        if (clear) begin
            pos_d   = '0;
            type_d  = TYPE_RST;
            en_d    = '0;
            speed_d = SPEED_W'(SPEED_INIT);
            dist_d  = '0;
            gap_d   = DIST_W'(MIN_GAP);
            cnt_d   = '0;
        end else if (tick_upd) begin
            for (int i = 0; i < 3; i++) begin
                if (en_q[i]) begin
                    if (pos_q[i] <= POS_W'(speed_q)) begin
                        en_d[i]   = 1'b0;
                        pos_d[i]  = '0;
                        type_d[i] = T_NOTHING;
                    end else begin
                        pos_d[i] = pos_q[i] - POS_W'(speed_q);
                    end
                end
            end

            dist_sum = {1'b0, dist_q} + (DIST_W + 1)'(speed_q);
            dist_d   = dist_sum[DIST_W] ? '1 : dist_sum[DIST_W-1:0];

            // Slots freed by the move above are already eligible.
            if (dist_d >= gap_q) begin
                for (int i = 0; i < 3; i++) begin
                    if (!en_d[i] && !spawned) begin
                        en_d[i]   = 1'b1;
                        pos_d[i]  = POS_W'(SPAWN_X);
                        type_d[i] = map_type(rnd_type, birds_ok);
                        spawned   = 1'b1;
                    end
                end
            end
            if (spawned) begin
                dist_d = '0;
                gap_d  = DIST_W'(MIN_GAP) + DIST_W'({rnd_gap, 1'b0});
            end

            if (cnt_q == CNT_W'(SPEED_STEP_FRAMES - 1)) begin
                cnt_d = '0;
                if (speed_q < SPEED_W'(SPEED_MAX)) speed_d = speed_q + 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            pos_q   <= '0;
            type_q  <= TYPE_RST;
            en_q    <= '0;
            speed_q <= SPEED_W'(SPEED_INIT);
            dist_q  <= '0;
            gap_q   <= DIST_W'(MIN_GAP);
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pos_q   <= pos_d;
            type_q  <= type_d;
            en_q    <= en_d;
            speed_q <= speed_d;
            dist_q  <= dist_d;
            gap_q   <= gap_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.new_danger_pos1 = pos_q[0];
    assign bus.new_danger_pos2 = pos_q[1];
    assign bus.new_danger_pos3 = pos_q[2];
    assign bus.danger_type1    = type_q[0];
    assign bus.danger_type2    = type_q[1];
    assign bus.danger_type3    = type_q[2];
    assign bus.danger_en1      = en_q[0];
    assign bus.danger_en2      = en_q[1];
    assign bus.danger_en3      = en_q[2];
    assign bus.cur_speed       = speed_q;

endmodule

// File: doc/danger_scheduler.md
Name: danger_scheduler

Overview:
- Owns the three obstacle slots consumed by the danger sprite renderer.
- Spawns obstacles at the right edge with a pseudo-random type and gap, and scrolls them left once per frame.
- Retires each obstacle once it leaves the screen, and ramps scroll speed over time.
- Sits between the game FSM (game_state, frame tick) and the renderer's pos/type/en inputs.

Parameters:
- SPAWN_X, 700: right-edge x of a newly spawned obstacle (10-bit, off-screen right).
- MIN_GAP, 200: minimum scrolled pixels between spawns.
- SPEED_INIT, 4: scroll pixels per frame after clear.
- SPEED_MAX, 12: speed ceiling (fits 4 bits).
- SPEED_STEP_FRAMES, 512: RUN frames per +1 speed step.
- LFSR_SEED, 16'hACE1: LFSR value after reset and after clear. Must be nonzero.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- game_state  in  2  0 INIT, 1 START, 2 END, 3 RESET.
- frame_tick  in  1  one-cycle pulse per video frame, asserted during vertical blank.
- new_danger_pos1/2/3  out  10  right-edge x of each slot.
- danger_type1/2/3  out  3  0 LOW_BIRD, 1 HIGH_BIRD, 2 SMALL_CACTUS, 3 MANY_CACTUS, 4 BIG_CACTUS, 5 NOTHING.
- danger_en1/2/3  out  1  slot occupied.
- cur_speed  out  4  current scroll speed, for the ground scroller.

Behaviour:
- Reset values:
  - all pos = 0, all type = 5, all en = 0;
  - cur_speed = SPEED_INIT;
  - dist = 0, gap_thr = MIN_GAP, frame_cnt = 0, lfsr = LFSR_SEED;
  - FSM = IDLE.
- FSM states: IDLE, RUN, FREEZE, CLEAR. The FSM is evaluated every clk.
  - Any state with game_state == 3: go to CLEAR.
  - CLEAR: re-applies every reset value except FSM, for one cycle, then goes to IDLE.
  - IDLE: game_state == 1 goes to RUN. Outputs hold.
  - RUN: game_state == 2 goes to FREEZE; game_state == 0 goes to IDLE.
  - FREEZE: outputs hold, no motion. Leaves only via game_state == 3.
- Frame update: only in RUN, on frame_tick. It is suppressed if the same cycle causes a state transition (the transition wins). All results are registered, so outputs change exactly 1 clk after the tick. Steps, in this order:
  1. Move. Each enabled slot: if pos <= cur_speed, set en = 0, pos = 0, type = 5; otherwise pos -= cur_speed.
  2. Distance. dist += cur_speed; dist is 11-bit and saturates at 2047.
  3. Spawn. If dist >= gap_thr and a slot is free after step 1, fill the lowest-index free slot:
     - pos = SPAWN_X, en = 1, type = map(lfsr[2:0]);
     - dist = 0, gap_thr = MIN_GAP + 2*lfsr[13:8].
     A slot freed in step 1 is spawnable in the same tick. If no slot is free, the spawn is deferred and dist keeps saturating.
  4. Speed ramp. frame_cnt += 1. When frame_cnt reaches SPEED_STEP_FRAMES: set frame_cnt = 0, and cur_speed += 1 if cur_speed < SPEED_MAX.
  5. LFSR. lfsr advances exactly once per tick. The step-3 values come from the pre-advance lfsr.
- map(): values 0–4 pass through; 5/6/7 map to 2/3/4.
- At most one spawn per tick.
- Slot order is fixed, so slot indices are not age-sorted.
- frame_tick is ignored outside RUN.

Optional Feature:
- Macro: DANGER_BIRD_EN.
- Defined: map() may produce types 0/1, but only while cur_speed >= SPEED_INIT+2. Below that speed, 0 maps to 2 and 1 maps to 4.
- Undefined: 0 maps to 2 and 1 maps to 4 always; birds never spawn.

Decomposition:
- Package danger_pkg:
  - type codes 0–5;
  - game_state codes 0–3;
  - POS_W = 10, TYPE_W = 3, SPEED_W = 4, DIST_W = 11;
  - FSM state enum.
- Sub-module danger_lfsr16:
  - 16-bit Galois LFSR, taps 16'hB400;
  - inputs: step (advance enable), load (load seed);
  - parameter SEED.

Test Plan:
- Reset, then game_state = 1, then 50 frame_ticks. Required response: the spawn lands 1 clk after tick 50 (dist = 200); slot1 en = 1, pos = 700, type = map(bits of the LFSR value before tick 50); slot2/3 en = 0.
- Continue with no spawns in slots 2/3 (force via large gap). Required response: slot1 pos = 696 after the next tick; after tick 175 from spawn, pos == 4 <= 4, so the slot retires to en = 0, pos = 0, type = 5.
- game_state = 2 asserted together with frame_tick. Required response: no movement, FSM goes to FREEZE, outputs hold over 10 further ticks.
- game_state = 3 from FREEZE. Required response: one cycle later all en = 0 and cur_speed = 4; FSM reaches IDLE the following cycle. Rerunning the first scenario yields an identical type sequence.
- 512 × 9 RUN ticks. Required response: cur_speed steps 4 → 5 at tick 512 and saturates at 12 from tick 4096.
- All three slots occupied with dist >= gap_thr. Required response: no spawn. On the tick slot1 retires, slot1 respawns at pos 700 in that same tick.
